// File: rtl/btn_stim_pkg.sv
// Shared definitions for the emulated button stimulus generator: FSM states,
// LFSR feedback taps, default seed and the hold-counter load helper.
package btn_stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_PRESS_BOUNCE   = 3'd1,
    S_HOLD           = 3'd2,
    S_RELEASE_BOUNCE = 3'd3,
    S_DONE           = 3'd4
  } state_e;

  // x^16+x^14+x^13+x^11 on a right-shifting register: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Down-counter load for a hold of max(len,1) cycles (terminal count at 0).
  function automatic logic [15:0] hold_load(input logic [15:0] len);
    return (len == 16'd0) ? 16'd0 : len - 16'd1;
  endfunction

endpackage

// File: rtl/btn_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR; advances one step per enabled cycle, loads SEED on reset.
module lfsr16
  import btn_stim_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/btn_bounce_gen.sv
// Emulates one mechanical button press/release per accepted start: optional
// pseudo-random bounce phases around a clean high hold, ending in a done pulse.
//
// Handshake: start is a request sampled only while idle (busy=0); it is consumed
// on the edge where busy rises. There is no backpressure and no queuing: any
// start seen while busy is dropped, and done pulses for exactly one cycle.
module btn_bounce_gen
  import btn_stim_pkg::*;
#(
  parameter int unsigned BOUNCE_CYC = 200,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] hold_len,
  input  logic        bounce_en,
  output logic        btn,
  output logic        busy,
  output logic        done,
  output state_e      dbg_state,
  output logic [15:0] dbg_lfsr
);

  localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        bnc_q, bnc_d;
  logic        btn_q, btn_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        lfsr_en;
  logic [15:0] lfsr_q;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (lfsr_en),
    .state_o (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      hold_q  <= 16'd0;
      bnc_q   <= 1'b0;
      btn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      bnc_q   <= bnc_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    bnc_d   = bnc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d = hold_len;
          bnc_d  = bounce_en;
          if (bounce_en) begin
            state_d = S_PRESS_BOUNCE;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            state_d = S_HOLD;
            cnt_d   = hold_load(hold_len);
          end
        end
      end
      S_PRESS_BOUNCE: begin
        if (cnt_q == 16'd0) begin
          state_d = S_HOLD;
          cnt_d   = hold_load(hold_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = bnc_q ? S_RELEASE_BOUNCE : S_DONE;
          cnt_d   = bnc_q ? BOUNCE_LOAD : 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RELEASE_BOUNCE: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Outputs are registered from the next state, so each bounce cycle shows the
  // LFSR bit present before that cycle's shift.
  always_comb begin
    lfsr_en = (state_d == S_PRESS_BOUNCE) || (state_d == S_RELEASE_BOUNCE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    btn_d   = 1'b0;
    if (lfsr_en) begin
      btn_d = lfsr_q[0];
    end else if (state_d == S_HOLD) begin
      btn_d = 1'b1;
    end
  end

  assign btn       = btn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr_q;

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Self-checking bench for btn_bounce_gen: the reference is the LFSR output bit
// stream (linear recurrence) plus the per-sequence btn/busy/done trace.
module tb_btn_bounce_gen;
  import btn_stim_pkg::*;

  localparam int BC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] hold_len;
  logic        bounce_en;
  logic        btn, busy, done;
  state_e      dbg_state;
  logic [15:0] dbg_lfsr;

  btn_bounce_gen #(.BOUNCE_CYC(BC), .LFSR_SEED(16'hACE1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold_len  (hold_len),
    .bounce_en (bounce_en),
    .btn       (btn),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .dbg_lfsr  (dbg_lfsr)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic       stream[0:511];
  int         pos;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Current register contents implied by the stream position: bit i is stream[pos+i].
  function automatic logic [15:0] model_lfsr();
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = stream[pos + i];
    return r;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".btn"},   16'(btn),       16'd0);
    chk({tag, ".busy"},  16'(busy),      16'd0);
    chk({tag, ".done"},  16'(done),      16'd0);
    chk({tag, ".state"}, 16'(dbg_state), 16'(S_IDLE));
    chk({tag, ".lfsr"},  dbg_lfsr,       model_lfsr());
  endtask

  // Starts one sequence from an idle negedge and checks every busy cycle plus
  // the idle cycle after it. Inputs are scrambled while busy; keep_start holds
  // start high so the next call is accepted in the first idle cycle.
  task automatic run_seq(input string tag, input logic [15:0] h, input logic ben,
                         input bit keep_start);
    int         hl;
    int         n;
    logic [2:0] e;
    hl = (h == 16'd0) ? 1 : int'(h);
    exp_q.delete();
    if (ben) begin
      for (int i = 0; i < BC; i++) exp_q.push_back({stream[pos + i], 2'b10});
      pos += BC;
    end
    for (int i = 0; i < hl; i++) exp_q.push_back(3'b110);
    if (ben) begin
      for (int i = 0; i < BC; i++) exp_q.push_back({stream[pos + i], 2'b10});
      pos += BC;
    end
    exp_q.push_back(3'b011);
    hold_len  = h;
    bounce_en = ben;
    start     = 1'b1;
    @(posedge clk);
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s.c%0d.btn", tag, n),  16'(btn),  16'(e[2]));
      chk($sformatf("%s.c%0d.busy", tag, n), 16'(busy), 16'(e[1]));
      chk($sformatf("%s.c%0d.done", tag, n), 16'(done), 16'(e[0]));
      start     = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
      hold_len  = 16'($urandom);
      bounce_en = 1'($urandom_range(0, 1));
      n++;
    end
    @(negedge clk);
    check_idle({tag, ".after"});
    if (!keep_start) start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) stream[i] = (16'hACE1 >> i) & 16'd1;
    for (int n = 0; n + 16 < 512; n++)
      stream[n + 16] = stream[n] ^ stream[n + 2] ^ stream[n + 3] ^ stream[n + 5];
    pos = 0;

    rst = 1'b1; start = 1'b0; hold_len = 16'd0; bounce_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    run_seq("clean_h5", 16'd5, 1'b0, 1'b0);
    run_seq("bounce_h3", 16'd3, 1'b1, 1'b0);
    run_seq("clean_h0", 16'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_seq("b2b_first", 16'd2, 1'b1, 1'b1);
    run_seq("b2b_second", 16'd4, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_seq($sformatf("rand%0d", k), 16'($urandom_range(0, 12)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset in the middle of a clean hold.
    hold_len = 16'd20; bounce_en = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    chk("pre_rst.btn", 16'(btn), 16'd1);
    #2 rst = 1'b1;
    #1;
    pos = 0;
    check_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_release");
    run_seq("reseeded", 16'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_bounce_gen.md
BTN_BOUNCE_GEN -- requirements
Module: btn_bounce_gen

Interface
REQ-001 Parameter BOUNCE_CYC, default 200: length in clk cycles of each bounce phase (1..65535).
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR value loaded at reset (must be nonzero).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request one press/release sequence; sampled only in IDLE.
REQ-006 hold_len  input  16  stable-high duration in cycles; latched when start is accepted.
REQ-007 bounce_en  input  1  1 = emit bounce phases, 0 = clean edges; latched when start is accepted.
REQ-008 btn  output  1  registered emulated mechanical button level.
REQ-009 busy  output  1  registered; high whenever FSM is not IDLE.
REQ-010 done  output  1  registered; one-cycle pulse at end of sequence.

Function
REQ-011 FSM states: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, DONE.
REQ-012 IDLE: btn=0, busy=0, done=0; start=1 at edge k latches hold_len/bounce_en; next state is PRESS_BOUNCE if bounce_en=1, else HOLD.
REQ-013 First cycle of the new state, with its btn value, is visible after edge k+1; latency start->first btn activity is 1 cycle.
REQ-014 PRESS_BOUNCE: exactly BOUNCE_CYC cycles, btn = LFSR bit 0 each cycle, then HOLD.
REQ-015 HOLD: btn=1 for exactly max(hold_len,1) cycles; hold_len=0 is treated as 1.
REQ-016 After HOLD: RELEASE_BOUNCE if latched bounce_en=1, else DONE.
REQ-017 RELEASE_BOUNCE: exactly BOUNCE_CYC cycles, btn = LFSR bit 0, then DONE.
REQ-018 DONE: exactly 1 cycle, btn=0, done=1, busy=1; then IDLE.
REQ-019 Total busy cycles: 2*BOUNCE_CYC + max(hold_len,1) + 1 with bounce, max(hold_len,1) + 1 without.
REQ-020 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11, shifts once per cycle only while in a bounce state; holds otherwise.
REQ-021 start while busy (including DONE): ignored, no queuing; hold_len/bounce_en changes while busy have no effect.
REQ-022 Counters are 16 bits, count down, never wrap; terminal count at 0 triggers the transition.

Reset
REQ-023 rst=1: immediately btn=0, busy=0, done=0, state IDLE, counters 0, LFSR=LFSR_SEED, regardless of phase.
REQ-024 After rst deasserts, first start is accepted at the first posedge with start=1; no partial sequence resumes.

Structure
REQ-025 Shared package btn_stim_pkg holds the FSM state enum, the LFSR tap mask, and the default seed constant.
REQ-026 One sub-module, lfsr16 (enable, seed-on-reset, 16-bit state out); the counters and FSM stay in btn_bounce_gen.

Verification
REQ-027 Reset: assert rst mid-HOLD -> btn, busy, done all 0 before the next clk edge; state IDLE, LFSR=16'hACE1.
REQ-028 bounce_en=0, hold_len=5, 1-cycle start -> btn=1 for exactly 5 cycles starting 1 cycle after start; done=1 on the 6th cycle with btn=0; busy=1 for 6 cycles.
REQ-029 BOUNCE_CYC=8, bounce_en=1, hold_len=3, seed 16'hACE1 -> btn matches a golden LFSR model for 8 cycles, then 1,1,1, then the next 8 LFSR bits, then done; busy=1 for 20 cycles.
REQ-030 hold_len=0, bounce_en=0 -> btn high exactly 1 cycle, done on the next cycle.
REQ-031 start pulsed again during HOLD and during DONE -> no effect on the sequence; a start 1 cycle after done is accepted.
REQ-032 Back-to-back sequences (start held high) -> second sequence begins in the first IDLE cycle; the LFSR continues and does not reseed, so bounce bits differ from the first sequence.
